// File: rtl/home_ctrl_pkg.sv
// Shared definitions for the home controller.
// Contents:
//   state_t        - controller state enumeration
//   DISP_*         - 3-bit display codes shown for each state
//   deb_cnt_width  - width of a debounce counter that counts 0..deb-1
package home_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ALARM,
    FDOOR,
    RDOOR,
    WINDOW,
    CLIMATE
  } state_t;

  localparam logic [2:0] DISP_IDLE   = 3'd0;
  localparam logic [2:0] DISP_FDOOR  = 3'd1;
  localparam logic [2:0] DISP_RDOOR  = 3'd2;
  localparam logic [2:0] DISP_WINDOW = 3'd3;
  localparam logic [2:0] DISP_ALARM  = 3'd4;
  localparam logic [2:0] DISP_HEAT   = 3'd5;
  localparam logic [2:0] DISP_COOL   = 3'd6;

  // The counter only ever holds 0..deb-1, so clog2(deb) bits suffice (min 1).
  function automatic int deb_cnt_width(input int deb);
    return (deb <= 2) ? 1 : $clog2(deb);
  endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Single-bit sensor debouncer.
// Ports:
//   Clk  - clock, rising edge
//   Rst  - asynchronous active-high reset (debounced value and count cleared)
//   raw  - raw sensor level
//   deb  - debounced level; follows raw after DEB consecutive disagreeing edges
module sensor_debounce
  import home_ctrl_pkg::*;
#(
  parameter int DEB = 4
) (
  input  logic Clk,
  input  logic Rst,
  input  logic raw,
  output logic deb
);

  localparam int CW = deb_cnt_width(DEB);
  localparam logic [CW-1:0] LAST = CW'(DEB - 1);

  logic [CW-1:0] cnt;

  // Count edges on which raw disagrees with deb; any agreement restarts the
  // count, and the DEB-th disagreeing edge adopts the raw level.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      deb <= 1'b0;
      cnt <= '0;
    end else if (raw == deb) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      deb <= raw;
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/home_ctrl_multi.sv
// Home controller: debounced doors, fire alarm and windows plus a
// hysteresis thermostat, arbitrated by a fixed-priority state machine.
// Ports:
//   Clk, Rst               - clock and asynchronous active-high reset
//   SFD, SRD, SFA          - raw front-door, rear-door and fire-alarm sensors
//   SW[NWIN-1:0]           - raw window sensors, 1 = open
//   ST[TW-1:0]             - unsigned temperature sample
//   AlarmAck               - releases a latched alarm once the fire input is clear
//   fdoor, rdoor, winbuzz,
//   alarmbuzz, heater,
//   cooler                 - registered actuator outputs
//   display[2:0]           - registered state code
//   win_idx[2:0]           - registered index of the lowest open window
module home_ctrl_multi
  import home_ctrl_pkg::*;
#(
  parameter int TW     = 7,
  parameter int NWIN   = 4,
  parameter int DEB    = 4,
  parameter int T_HEAT = 50,
  parameter int T_COOL = 60,
  parameter int HYST   = 2
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic            SFD,
  input  logic            SRD,
  input  logic            SFA,
  input  logic [NWIN-1:0] SW,
  input  logic [TW-1:0]   ST,
  input  logic            AlarmAck,
  output logic            fdoor,
  output logic            rdoor,
  output logic            winbuzz,
  output logic            alarmbuzz,
  output logic            heater,
  output logic            cooler,
  output logic [2:0]      display,
  output logic [2:0]      win_idx
);

  if (!(T_HEAT + HYST < T_COOL - HYST) || !(T_COOL < (2 ** TW))) begin : g_bad_thresholds
    $error("home_ctrl_multi: invalid temperature thresholds");
  end
  if (NWIN < 1 || NWIN > 8 || DEB < 2 || DEB > 255) begin : g_bad_sizes
    $error("home_ctrl_multi: NWIN or DEB out of range");
  end

  localparam logic [TW-1:0] HEAT_ON  = TW'(T_HEAT);
  localparam logic [TW-1:0] HEAT_OFF = TW'(T_HEAT + HYST);
  localparam logic [TW-1:0] COOL_ON  = TW'(T_COOL);
  localparam logic [TW-1:0] COOL_OFF = TW'(T_COOL - HYST);

  logic            fd_deb, rd_deb, sfa_deb;
  logic [NWIN-1:0] sw_deb;

  sensor_debounce #(.DEB(DEB)) u_deb_fd  (.Clk(Clk), .Rst(Rst), .raw(SFD), .deb(fd_deb));
  sensor_debounce #(.DEB(DEB)) u_deb_rd  (.Clk(Clk), .Rst(Rst), .raw(SRD), .deb(rd_deb));
  sensor_debounce #(.DEB(DEB)) u_deb_sfa (.Clk(Clk), .Rst(Rst), .raw(SFA), .deb(sfa_deb));

  for (genvar i = 0; i < NWIN; i++) begin : g_win
    sensor_debounce #(.DEB(DEB)) u_deb_win (.Clk(Clk), .Rst(Rst), .raw(SW[i]), .deb(sw_deb[i]));
  end

  state_t     state, next_state;
  logic       sfa_prev, alarm_q, heat_q, cool_q;
  logic       alarm_next, heat_next, cool_next, any_win;
  logic [2:0] low_idx;

  // Alarm latch: a rising debounced fire input always sets it (so a
  // coincident acknowledge loses); acknowledge only clears once fire is gone.
  always_comb begin
    alarm_next = alarm_q;
    if (sfa_deb && !sfa_prev)
      alarm_next = 1'b1;
    else if (AlarmAck && !sfa_deb)
      alarm_next = 1'b0;
  end

  // Thermostat demands with hysteresis; tracked every cycle in every state.
  always_comb begin
    heat_next = heat_q;
    if (ST < HEAT_ON)
      heat_next = 1'b1;
    else if (ST >= HEAT_OFF)
      heat_next = 1'b0;
    cool_next = cool_q;
    if (ST > COOL_ON)
      cool_next = 1'b1;
    else if (ST <= COOL_OFF)
      cool_next = 1'b0;
  end

  // Lowest open window: scan downward so the smallest index wins.
  always_comb begin
    low_idx = '0;
    any_win = |sw_deb;
    for (int i = NWIN - 1; i >= 0; i--)
      if (sw_deb[i])
        low_idx = 3'(i);
  end

  // Fixed-priority arbitration; every branch is decided fresh each cycle.
  always_comb begin
    next_state = state;
    if (alarm_next)
      next_state = ALARM;
    else if (fd_deb)
      next_state = FDOOR;
    else if (rd_deb)
      next_state = RDOOR;
    else if (any_win)
      next_state = WINDOW;
    else if (heat_next || cool_next)
      next_state = CLIMATE;
    else
      next_state = IDLE;
  end

  // Outputs are decoded from next_state so they change on the same edge
  // as the state register.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state     <= IDLE;
      alarm_q   <= 1'b0;
      sfa_prev  <= 1'b0;
      heat_q    <= 1'b0;
      cool_q    <= 1'b0;
      win_idx   <= '0;
      fdoor     <= 1'b0;
      rdoor     <= 1'b0;
      winbuzz   <= 1'b0;
      alarmbuzz <= 1'b0;
      heater    <= 1'b0;
      cooler    <= 1'b0;
      display   <= DISP_IDLE;
    end else begin
      state     <= next_state;
      alarm_q   <= alarm_next;
      sfa_prev  <= sfa_deb;
      heat_q    <= heat_next;
      cool_q    <= cool_next;
      if (any_win)
        win_idx <= low_idx;
      fdoor     <= 1'b0;
      rdoor     <= 1'b0;
      winbuzz   <= 1'b0;
      alarmbuzz <= 1'b0;
      heater    <= 1'b0;
      cooler    <= 1'b0;
      display   <= DISP_IDLE;
      case (next_state)
        ALARM: begin
          alarmbuzz <= 1'b1;
          fdoor     <= 1'b1;
          rdoor     <= 1'b1;
          display   <= DISP_ALARM;
        end
        FDOOR: begin
          fdoor   <= 1'b1;
          display <= DISP_FDOOR;
        end
        RDOOR: begin
          rdoor   <= 1'b1;
          display <= DISP_RDOOR;
        end
        WINDOW: begin
          winbuzz <= 1'b1;
          display <= DISP_WINDOW;
        end
        CLIMATE: begin
          heater  <= heat_next;
          cooler  <= cool_next & ~heat_next;
          display <= cool_next ? DISP_COOL : DISP_HEAT;
        end
        default: display <= DISP_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_home_ctrl_multi.sv
// Self-checking bench for home_ctrl_multi with default parameters.
// A reference model predicts the outputs after every clock edge and queues
// them; a monitor compares each queued prediction on the following falling
// edge. Directed scenarios add absolute checks on top of the scoreboard.
module tb_home_ctrl_multi;

  localparam int NWIN = 4;
  localparam int DEB  = 4;
  localparam int NS   = 3 + NWIN;

  typedef struct packed {
    logic       fdoor;
    logic       rdoor;
    logic       winbuzz;
    logic       alarmbuzz;
    logic       heater;
    logic       cooler;
    logic [2:0] display;
    logic [2:0] win_idx;
  } out_t;

  logic            Clk = 1'b0;
  logic            Rst;
  logic            SFD, SRD, SFA, AlarmAck;
  logic [NWIN-1:0] SW;
  logic [6:0]      ST;
  logic            fdoor, rdoor, winbuzz, alarmbuzz, heater, cooler;
  logic [2:0]      display, win_idx;

  int passed = 0;
  int total  = 0;

  out_t exp_q[$];

  home_ctrl_multi dut (
    .Clk(Clk), .Rst(Rst), .SFD(SFD), .SRD(SRD), .SFA(SFA), .SW(SW), .ST(ST),
    .AlarmAck(AlarmAck), .fdoor(fdoor), .rdoor(rdoor), .winbuzz(winbuzz),
    .alarmbuzz(alarmbuzz), .heater(heater), .cooler(cooler),
    .display(display), .win_idx(win_idx)
  );

  always #5 Clk = ~Clk;

  // Reference model state: per-sensor run length of the current raw level
  // and the debounced view, plus alarm/thermostat bookkeeping.
  bit         deb_v[NS];
  bit         last_raw[NS];
  int         run_len[NS];
  bit         m_alarm, m_prev_sfa, m_heat, m_cool;
  logic [2:0] m_idx;
  out_t       m_out;

  function automatic out_t dut_out();
    return out_t'({fdoor, rdoor, winbuzz, alarmbuzz, heater, cooler, display, win_idx});
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      deb_v[i] = 0; last_raw[i] = 0; run_len[i] = 0;
    end
    m_alarm = 0; m_prev_sfa = 0; m_heat = 0; m_cool = 0;
    m_idx = 0;
    m_out = '0;
  endtask

  // One clock edge: outputs are decided from the debounced view held before
  // the edge, then the debounced view absorbs the raw levels sampled now.
  task automatic model_step();
    bit   raw[NS];
    bit   any;
    out_t o;
    if (Rst) begin
      model_reset();
      return;
    end
    if (deb_v[2] && !m_prev_sfa) m_alarm = 1;
    else if (AlarmAck && !deb_v[2]) m_alarm = 0;
    m_prev_sfa = deb_v[2];
    if (ST < 50) m_heat = 1; else if (ST >= 52) m_heat = 0;
    if (ST > 60) m_cool = 1; else if (ST <= 58) m_cool = 0;
    any = 0;
    for (int i = 0; i < NWIN; i++)
      if (!any && deb_v[3+i]) begin any = 1; m_idx = 3'(i); end
    o = '0;
    o.win_idx = m_idx;
    if (m_alarm) begin
      o.alarmbuzz = 1; o.fdoor = 1; o.rdoor = 1; o.display = 4;
    end else if (deb_v[0]) begin
      o.fdoor = 1; o.display = 1;
    end else if (deb_v[1]) begin
      o.rdoor = 1; o.display = 2;
    end else if (any) begin
      o.winbuzz = 1; o.display = 3;
    end else if (m_heat || m_cool) begin
      o.heater = m_heat; o.cooler = m_cool; o.display = m_cool ? 6 : 5;
    end
    m_out = o;
    raw[0] = SFD; raw[1] = SRD; raw[2] = SFA;
    for (int i = 0; i < NWIN; i++) raw[3+i] = SW[i];
    for (int i = 0; i < NS; i++) begin
      if (raw[i] == last_raw[i]) run_len[i]++; else run_len[i] = 1;
      last_raw[i] = raw[i];
      if (run_len[i] >= DEB && raw[i] != deb_v[i]) deb_v[i] = raw[i];
    end
  endtask

  // One clock: predict at the rising edge, return at the falling edge where
  // inputs may safely change.
  task automatic applyStimulus();
    @(posedge Clk);
    model_step();
    exp_q.push_back(m_out);
    @(negedge Clk);
  endtask

  task automatic checkOutput(input string name, input logic [11:0] act, input logic [11:0] req);
    total++;
    if (act === req) passed++;
    else $display("[TB] FAIL %s: got %0h required %0h", name, act, req);
  endtask

  // Reset raised between edges: outputs must clear without a clock edge.
  task automatic pulse_reset_async();
    @(posedge Clk);
    model_step();
    exp_q.push_back(m_out);
    #2;
    Rst = 1'b1;
    model_reset();
    exp_q.delete();
    exp_q.push_back(m_out);
    #1;
    checkOutput("async reset outputs", 12'(dut_out()), 12'h000);
    @(negedge Clk);
    Rst = 1'b0;
  endtask

  initial begin : monitor
    out_t e;
    forever begin
      @(negedge Clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if (dut_out() === e) passed++;
        else $display("[TB] FAIL scoreboard @%0t: dut=%03h expected=%03h", $time, dut_out(), e);
      end
    end
  end

  initial begin : stimulus
    Rst = 1'b1; SFD = 0; SRD = 0; SFA = 0; AlarmAck = 0; SW = '0; ST = 7'd55;
    model_reset();
    applyStimulus();
    checkOutput("reset state", 12'(dut_out()), 12'h000);
    Rst = 1'b0;
    repeat (2) applyStimulus();

    // Front door: 4 held edges debounce, output on the 5th.
    SFD = 1;
    repeat (4) applyStimulus();
    checkOutput("fdoor before latency", {11'd0, fdoor}, 12'd0);
    SFD = 0;
    applyStimulus();
    checkOutput("fdoor edge5", {11'd0, fdoor}, 12'd1);
    checkOutput("fdoor display", {9'd0, display}, 12'd1);
    repeat (5) applyStimulus();
    SFD = 1;
    repeat (3) applyStimulus();
    SFD = 0;
    repeat (6) applyStimulus();
    checkOutput("short pulse ignored", {11'd0, fdoor}, 12'd0);

    // Windows: lowest open index, then hold when all close.
    SW = 4'b0110;
    repeat (5) applyStimulus();
    checkOutput("winbuzz", {11'd0, winbuzz}, 12'd1);
    checkOutput("win_idx 1", {9'd0, win_idx}, 12'd1);
    checkOutput("window display", {9'd0, display}, 12'd3);
    SW = 4'b0100;
    repeat (5) applyStimulus();
    checkOutput("win_idx 2", {9'd0, win_idx}, 12'd2);
    SW = 4'b0000;
    repeat (5) applyStimulus();
    checkOutput("win_idx hold", {9'd0, win_idx}, 12'd2);
    checkOutput("idle after windows", {9'd0, display}, 12'd0);

    // Heater and cooler hysteresis sweeps.
    ST = 55; applyStimulus(); checkOutput("heater@55", {11'd0, heater}, 12'd0);
    ST = 48; applyStimulus(); checkOutput("heater@48", {11'd0, heater}, 12'd1);
    checkOutput("heat display", {9'd0, display}, 12'd5);
    ST = 51; applyStimulus(); checkOutput("heater@51", {11'd0, heater}, 12'd1);
    ST = 52; applyStimulus(); checkOutput("heater@52", {11'd0, heater}, 12'd0);
    ST = 55; applyStimulus(); checkOutput("cooler@55", {11'd0, cooler}, 12'd0);
    ST = 61; applyStimulus(); checkOutput("cooler@61", {11'd0, cooler}, 12'd1);
    checkOutput("cool display", {9'd0, display}, 12'd6);
    ST = 59; applyStimulus(); checkOutput("cooler@59", {11'd0, cooler}, 12'd1);
    ST = 58; applyStimulus(); checkOutput("cooler@58", {11'd0, cooler}, 12'd0);
    ST = 55; applyStimulus();

    // Alarm pulse latches until acknowledged.
    SFA = 1;
    repeat (4) applyStimulus();
    SFA = 0;
    repeat (8) applyStimulus();
    checkOutput("alarm held", 12'(dut_out()), {6'b110100, 3'd4, win_idx});
    AlarmAck = 1;
    applyStimulus();
    checkOutput("alarm released", {9'd0, display}, 12'd0);
    AlarmAck = 0;

    // Acknowledge ignored while fire persists.
    SFA = 1; AlarmAck = 1;
    repeat (12) applyStimulus();
    checkOutput("ack ignored", {9'd0, display}, 12'd4);
    SFA = 0;
    repeat (6) applyStimulus();
    checkOutput("ack after clear", {9'd0, display}, 12'd0);
    AlarmAck = 0;

    // Alarm beats front door.
    SFD = 1; SFA = 1;
    repeat (5) applyStimulus();
    checkOutput("alarm priority", {9'd0, display}, 12'd4);
    SFD = 0; SFA = 0;
    repeat (5) applyStimulus();
    AlarmAck = 1; applyStimulus(); AlarmAck = 0;
    repeat (5) applyStimulus();

    // Asynchronous reset mid-alarm, then mid-debounce.
    SFA = 1;
    repeat (5) applyStimulus();
    checkOutput("alarm before reset", {9'd0, display}, 12'd4);
    SFA = 0;
    pulse_reset_async();
    repeat (3) applyStimulus();
    checkOutput("alarm discarded", {9'd0, display}, 12'd0);
    SFD = 1;
    repeat (2) applyStimulus();
    pulse_reset_async();
    repeat (4) applyStimulus();
    checkOutput("debounce restarted", {11'd0, fdoor}, 12'd0);
    applyStimulus();
    checkOutput("reacquired", {11'd0, fdoor}, 12'd1);
    SFD = 0;
    repeat (6) applyStimulus();

    // Randomized traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 5) == 0) SFD = ~SFD;
      if ($urandom_range(0, 5) == 0) SRD = ~SRD;
      if ($urandom_range(0, 19) == 0) SFA = ~SFA;
      for (int i = 0; i < NWIN; i++)
        if ($urandom_range(0, 5) == 0) SW[i] = ~SW[i];
      AlarmAck = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 39) == 0) ST = ($urandom_range(0, 1) == 0) ? 7'd0 : 7'd127;
      else if ($urandom_range(0, 2) == 0) ST = 7'($urandom_range(44, 66));
      if ($urandom_range(0, 399) == 0) pulse_reset_async();
      else applyStimulus();
    end

    for (int k = 0; k < 4 && exp_q.size() != 0; k++) @(negedge Clk);
    if (exp_q.size() != 0) begin
      total++;
      $display("[TB] FAIL drain: %0d predictions left, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
